traffic_sensor: RTL and testbench
=================================

Name: traffic_sensor

Overview:
- Roadside model for the intersection controller; it sits on the opposite side of the `Ta`/`Tb`/`La`/`Lb` interface.
- It consumes the controller's light outputs and per-street car-arrival pulses.
- It keeps a vehicle queue per street and releases queued cars while that street is green.
- It drives the traffic sensors `Ta`/`Tb` high whenever cars are waiting, and flags light-protocol violations (sticky error bits).

Parameters:
- QW, 4: width of each queue counter; capacity is 2^QW-1 cars.
- DEPART_CYC, 2: clock cycles one car needs to clear the intersection while green (must be 1 or more).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- La  input  2  street A light: 0=green, 1=yellow, 2=red, 3=illegal.
- Lb  input  2  street B light, same encoding as La.
- arr_a  input  1  one-cycle pulse: a car arrives on street A.
- arr_b  input  1  one-cycle pulse: a car arrives on street B.
- Ta  output  1  street A sensor; high while qa != 0.
- Tb  output  1  street B sensor; high while qb != 0.
- qa  output  QW  street A queue occupancy.
- qb  output  QW  street B queue occupancy.
- dep_a  output  1  one-cycle pulse: a car left street A.
- dep_b  output  1  one-cycle pulse: a car left street B.
- err  output  3  sticky flags: [0] conflict, [1] illegal code, [2] queue overflow.

Behaviour:
- Reset (rst high at a clock edge):
  - qa=qb=0, Ta=Tb=0, dep_a=dep_b=0, err=0.
  - Both direction FSMs go to IDLE and both departure timers clear to 0.
  - Reset mid-service abandons the car in progress; no dep pulse is produced.
- Sensors: Ta = (qa != 0) and Tb = (qb != 0), decoded from the registered counts.
  - Ta therefore rises the cycle after the edge that samples the first arrival pulse.
- Each direction runs an identical, independent FSM (A shown; B uses Lb/arr_b/qb/dep_b).
  - IDLE: timer=0. Go to SERVE when La==green and qa!=0.
  - SERVE: timer increments each cycle.
    - When timer reaches DEPART_CYC-1 and La is still green: decrement qa, pulse dep_a for one cycle, clear timer.
    - After that departure, stay in SERVE if qa-1 != 0 and still green; otherwise go to IDLE.
  - Leaving green (yellow, red or illegal) while in SERVE returns to IDLE immediately; the timer clears, no departure, qa unchanged.
  - Departures never start or complete while yellow.
  - Minimum spacing between dep_a pulses is DEPART_CYC cycles; the first departure follows entry to SERVE after DEPART_CYC cycles.
- Queue arithmetic:
  - Arrival and departure in the same cycle leaves qa unchanged; dep_a still pulses.
  - Arrival only: qa+1, saturating at 2^QW-1.
    - An arrival at saturation (with no simultaneous departure) is dropped and sets err[2].
  - qa never underflows, because departure requires qa != 0.
- Protocol checks (sampled every cycle after reset):
  - err[0] set when La != red and Lb != red in the same cycle.
  - err[1] set when La==3 or Lb==3.
  - err bits are sticky until rst; they do not alter queue behaviour.
- All outputs are registered except Ta/Tb, which are decoded from the registered qa/qb.

Test Plan (DEPART_CYC=2, QW=4):
- Reset, La=red, Lb=green, no arrivals → all outputs 0 for 10 cycles; err=0.
- La=red, 3 arr_a pulses on consecutive cycles → qa=1,2,3; Ta rises the cycle after the first pulse; no dep_a.
- qa=3, then La→green held → dep_a pulses 2, 4 and 6 cycles after the green edge; qa goes 2,1,0; Ta falls with qa=0; FSM returns to IDLE.
- qa=2, La green for 1 cycle then yellow → no dep_a, qa stays 2. A later green restarts the full 2-cycle timer.
- qa=15, then arr_a with La=red → qa stays 15, err[2]=1. Then arr_a coincident with dep_a → qa unchanged, dep_a=1.
- La=green with Lb=yellow for 1 cycle → err[0]=1 and stays 1 after lights return legal. Lb=3 → err[1]=1. rst clears err to 0.

Source files
------------

// File: rtl/traffic_sensor.sv
// ---------------------------------------------------------------------------
// traffic_sensor
//   Roadside model that sits opposite an intersection controller. It reads
//   the controller's light codes (La/Lb), counts arriving cars per street,
//   releases one car every DEPART_CYC cycles while that street is green, and
//   drives the car-present sensors Ta/Tb back to the controller. Protocol
//   violations are latched into sticky error bits.
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   La, Lb       light codes: 0=green 1=yellow 2=red 3=illegal
//   arr_a/arr_b  one-cycle car-arrival pulses
//   Ta, Tb       sensor outputs, high while the street's queue is non-empty
//   qa, qb       queue occupancy (QW bits, saturating at 2^QW-1)
//   dep_a/dep_b  one-cycle car-departure pulses (registered)
//   err          sticky: [0] both lights non-red, [1] illegal code,
//                [2] arrival dropped at a full queue
// ---------------------------------------------------------------------------

// Per-street lane: queue counter plus IDLE/SERVE departure FSM.
//   light_i  street light code       arr_i  arrival pulse
//   q_o      registered occupancy    dep_o  registered departure pulse
//   ovf_o    combinational: this cycle's arrival is being dropped
module traffic_lane #(
  parameter int QW         = 4,
  parameter int DEPART_CYC = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    light_i,
  input  logic          arr_i,
  output logic [QW-1:0] q_o,
  output logic          dep_o,
  output logic          ovf_o
);

  localparam int TW = (DEPART_CYC > 1) ? $clog2(DEPART_CYC) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(DEPART_CYC - 1);
  localparam logic [QW-1:0] Q_MAX  = {QW{1'b1}};
  localparam logic [1:0]    GREEN  = 2'd0;

  typedef enum logic {IDLE, SERVE} state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [QW-1:0] q_q, q_d;
  logic          dep_q;
  logic          depart;
  logic          green;

  assign green = (light_i == GREEN);

  // Departure FSM. Any non-green code aborts the car in progress; the timer
  // always restarts from zero on the next entry to SERVE.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    depart  = 1'b0;
    unique case (state_q)
      IDLE: begin
        timer_d = '0;
        if (green && q_q != '0) state_d = SERVE;
      end
      SERVE: begin
        if (!green) begin
          state_d = IDLE;
          timer_d = '0;
        end else if (timer_q == T_LAST && q_q != '0) begin
          depart  = 1'b1;
          timer_d = '0;
          // Last car leaving: nothing left to serve.
          if (q_q == QW'(1)) state_d = IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase
  end

  // Queue arithmetic: simultaneous arrival and departure cancel out.
  always_comb begin
    q_d   = q_q;
    ovf_o = 1'b0;
    if (arr_i && !depart) begin
      if (q_q == Q_MAX) ovf_o = 1'b1;
      else              q_d   = q_q + QW'(1);
    end else if (depart && !arr_i) begin
      q_d = q_q - QW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      timer_q <= '0;
      q_q     <= '0;
      dep_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      q_q     <= q_d;
      dep_q   <= depart;
    end
  end

  assign q_o   = q_q;
  assign dep_o = dep_q;

endmodule

module traffic_sensor #(
  parameter int QW         = 4,
  parameter int DEPART_CYC = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    La,
  input  logic [1:0]    Lb,
  input  logic          arr_a,
  input  logic          arr_b,
  output logic          Ta,
  output logic          Tb,
  output logic [QW-1:0] qa,
  output logic [QW-1:0] qb,
  output logic          dep_a,
  output logic          dep_b,
  output logic [2:0]    err
);

  localparam int NUM_LANES = 2;
  localparam logic [1:0] RED     = 2'd2;
  localparam logic [1:0] ILLEGAL = 2'd3;

  // Lane 0 is street A, lane 1 is street B.
  logic [NUM_LANES-1:0][1:0]    light;
  logic [NUM_LANES-1:0]         arr;
  logic [NUM_LANES-1:0][QW-1:0] q;
  logic [NUM_LANES-1:0]         dep;
  logic [NUM_LANES-1:0]         ovf;
  logic [2:0]                   err_q, err_d;

  assign light = {Lb, La};
  assign arr   = {arr_b, arr_a};

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    traffic_lane #(
      .QW         (QW),
      .DEPART_CYC (DEPART_CYC)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .light_i (light[l]),
      .arr_i   (arr[l]),
      .q_o     (q[l]),
      .dep_o   (dep[l]),
      .ovf_o   (ovf[l])
    );
  end

  // Sticky protocol/overflow flags; they never feed back into the lanes.
  always_comb begin
    err_d    = err_q;
    err_d[0] = err_q[0] | ((La != RED) && (Lb != RED));
    err_d[1] = err_q[1] | (La == ILLEGAL) | (Lb == ILLEGAL);
    err_d[2] = err_q[2] | (|ovf);
  end

  always_ff @(posedge clk) begin
    if (rst) err_q <= '0;
    else     err_q <= err_d;
  end

  assign qa    = q[0];
  assign qb    = q[1];
  assign Ta    = (q[0] != '0);
  assign Tb    = (q[1] != '0);
  assign dep_a = dep[0];
  assign dep_b = dep[1];
  assign err   = err_q;

endmodule

// File: tb/tb_traffic_sensor.sv
// Directed bench for traffic_sensor (QW=4, DEPART_CYC=2). Inputs change 1ns
// after each rising edge; outputs are checked at the same point.
module tb_traffic_sensor;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] La, Lb;
  logic       arr_a, arr_b;
  logic       Ta, Tb;
  logic [3:0] qa, qb;
  logic       dep_a, dep_b;
  logic [2:0] err;

  int checks   = 0;
  int failures = 0;

  traffic_sensor #(.QW(4), .DEPART_CYC(2)) dut (
    .clk   (clk),
    .rst   (rst),
    .La    (La),
    .Lb    (Lb),
    .arr_a (arr_a),
    .arr_b (arr_b),
    .Ta    (Ta),
    .Tb    (Tb),
    .qa    (qa),
    .qb    (qb),
    .dep_a (dep_a),
    .dep_b (dep_b),
    .err   (err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // All outputs packed: {Ta,Tb,dep_a,dep_b,err} and the two queues.
  task automatic chk_all(input string tag, input logic [3:0] eqa, input logic [3:0] eqb,
                         input logic eta, input logic etb, input logic eda,
                         input logic edb, input logic [2:0] eerr);
    chk({tag, "_q"},   {qa, qb}, {eqa, eqb});
    chk({tag, "_ctl"}, {1'b0, Ta, Tb, dep_a, dep_b, err}, {1'b0, eta, etb, eda, edb, eerr});
  endtask

  initial begin
    rst = 1'b1; La = 2'd2; Lb = 2'd0; arr_a = 1'b0; arr_b = 1'b0;
    step(); step();
    chk_all("reset", 4'd0, 4'd0, 0, 0, 0, 0, 3'b000);
    rst = 1'b0;

    // Idle: La red, Lb green, no cars.
    for (int i = 0; i < 10; i++) begin
      step();
      chk_all("idle", 4'd0, 4'd0, 0, 0, 0, 0, 3'b000);
    end

    // Three arrivals on A while red.
    arr_a = 1'b1;
    step(); chk_all("arr1", 4'd1, 4'd0, 1, 0, 0, 0, 3'b000);
    step(); chk_all("arr2", 4'd2, 4'd0, 1, 0, 0, 0, 3'b000);
    step(); chk_all("arr3", 4'd3, 4'd0, 1, 0, 0, 0, 3'b000);
    arr_a = 1'b0;

    // A goes green (B red): departures 2,4,6 cycles after the green edge.
    La = 2'd0; Lb = 2'd2;
    step(); chk("grn_enter_dep", dep_a, 1'b0); chk("grn_enter_q", qa, 4'd3);
    for (int i = 1; i <= 6; i++) begin
      step();
      chk("dep_seq", dep_a, 8'((i % 2) == 0));
      chk("q_seq",   qa,    8'(3 - i / 2));
    end
    chk("ta_fall", Ta, 1'b0);
    step(); chk("idle_after_drain", {dep_a, qa}, 5'd0);
    La = 2'd2;

    // Two cars, then green for one cycle followed by yellow: no departure.
    arr_a = 1'b1; step(); step(); arr_a = 1'b0;
    chk("q_two", qa, 4'd2);
    La = 2'd0; step(); chk("short_grn_dep", dep_a, 1'b0);
    La = 2'd1; step(); chk("yel_abort", {dep_a, qa}, {1'b0, 4'd2});
    step();           chk("yel_hold",  {dep_a, qa}, {1'b0, 4'd2});
    // Green again: full 2-cycle wait from entry.
    La = 2'd0; step(); chk("regrn_enter", dep_a, 1'b0);
    step();            chk("regrn_t1", {dep_a, qa}, {1'b0, 4'd2});
    step();            chk("regrn_dep", {dep_a, qa}, {1'b1, 4'd1});
    La = 2'd1; step(); chk("regrn_yel", {dep_a, qa}, {1'b0, 4'd1});
    La = 2'd2;

    // Fill to saturation, then overflow.
    arr_a = 1'b1;
    for (int i = 0; i < 14; i++) step();
    chk_all("full", 4'd15, 4'd0, 1, 0, 0, 0, 3'b000);
    step();
    chk_all("overflow", 4'd15, 4'd0, 1, 0, 0, 0, 3'b100);
    arr_a = 1'b0;

    // Arrival coincident with a departure at saturation: no change, no error.
    La = 2'd0; step(); step();
    arr_a = 1'b1; step();
    chk_all("arr_dep_same", 4'd15, 4'd0, 1, 0, 1, 0, 3'b100);
    arr_a = 1'b0; La = 2'd2; step();
    chk("abort_red", {dep_a, qa}, {1'b0, 4'd15});

    // Street B: one car served while B is green.
    Lb = 2'd0; arr_b = 1'b1; step(); arr_b = 1'b0;
    chk_all("b_arr", 4'd15, 4'd1, 1, 1, 0, 0, 3'b100);
    step(); step(); chk("b_wait", dep_b, 1'b0);
    step(); chk_all("b_dep", 4'd15, 4'd0, 1, 0, 0, 1, 3'b100);

    // Conflict: A green with B yellow.
    La = 2'd0; Lb = 2'd1; step(); chk("conflict", err, 3'b101);
    La = 2'd2; Lb = 2'd0; step(); chk("conflict_sticky", err, 3'b101);
    Lb = 2'd3; step(); chk("illegal", err, 3'b111);
    Lb = 2'd2; step(); chk("illegal_sticky", err, 3'b111);

    rst = 1'b1; step(); rst = 1'b0;
    chk_all("rst_clear", 4'd0, 4'd0, 0, 0, 0, 0, 3'b000);

    // Reset in the middle of service drops the car with no departure.
    arr_a = 1'b1; step(); arr_a = 1'b0;
    chk("mid_q", qa, 4'd1);
    La = 2'd0; step(); step();
    rst = 1'b1; step(); rst = 1'b0;
    chk_all("mid_rst", 4'd0, 4'd0, 0, 0, 0, 0, 3'b000);
    step();
    chk("mid_rst_nodep", {dep_a, qa}, 5'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
